keyboard_matrix_cache: RTL and testbench
========================================

Name: keyboard_matrix_cache

Overview:
- Synchronous, parametrised keyboard-matrix cache for the PET clone. Replaces the edge-clocked matrix with a single-clock design.
- The Pi fills a shadow matrix and commits it atomically, so the CPU never reads a half-updated scan.
- The CPU's PIA1 row-select writes and port-B reads are tracked. Port-B data is intercepted whenever the selected cached row shows a pressed key.
- A watchdog releases all keys if the Pi stops committing updates.

Parameters:
- NUM_ROWS, 10, number of matrix rows (1..15).
- COL_WIDTH, 8, columns per row (1..8). Unused upper data bits read as 1.
- BASE_ADDR, 16'hE800, Pi address of row 0. The commit/control register is at BASE_ADDR+15.
- TIMEOUT_CYCLES, 24'd6000000, clk cycles without a commit before auto-release. 0 disables the watchdog.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pi_addr  in  16  Pi bus address.
- pi_data  in  8  Pi write data.
- pi_write_strobe  in  1  Pi write strobe, synchronous to clk. Acts on its rising edge.
- bus_addr  in  2  CPU register select (0=PORTA, 1=CRA, 2=PORTB, 3=CRB).
- bus_data_in  in  8  CPU write data.
- bus_rw_b  in  1  CPU read (1) / write (0).
- pia1_enabled_in  in  1  PIA1 chip select.
- io_select  in  1  I/O cycle active.
- cpu_write_strobe  in  1  CPU write strobe.
- kbd_data_out  out  8  data driven to CPU on an intercepted port-B read.
- kbd_enable  out  1  high when kbd_data_out must override the PIA.
- key_pressed_any  out  1  any bit of the active matrix is 0.
- stale  out  1  watchdog has fired, or no commit has occurred since reset.

Behaviour:
- Reset values:
  - Every shadow and active row = all 1s; row_sel = 0.
  - kbd_data_out = 8'hFF; kbd_enable = 0; key_pressed_any = 0.
  - stale = 1; watchdog counter = 0.
- Pi writes:
  - pi_write_strobe is registered each clk. A write occurs in the cycle where the current sample is 1 and the previous sample is 0. A held strobe causes exactly one write.
  - Row write, BASE_ADDR <= pi_addr <= BASE_ADDR+NUM_ROWS-1: shadow[pi_addr-BASE_ADDR] <= pi_data[COL_WIDTH-1:0]. The active matrix is unchanged.
  - Control write, pi_addr = BASE_ADDR+15:
    - pi_data[0]=1 (commit): all active rows <= shadow rows in the same clk; watchdog counter <= 0; stale <= 0.
    - pi_data[1]=1 (release-all): all shadow and active rows <= all 1s; stale is unchanged.
    - Bits 0 and 1 both set: release-all wins, but the counter still clears and stale <= 0.
  - Any other address: ignored.
- Row select:
  - writing_port_a = cpu_write_strobe & pia1_enabled_in & (bus_addr==0).
  - On its registered 1->0 transition, row_sel <= the bus_data_in[3:0] value sampled in the last cycle writing_port_a was high.
- Port-B read:
  - reading_port_b = io_select & bus_rw_b & pia1_enabled_in & (bus_addr==2).
  - While reading_port_b=0, every clk: kbd_data_out <= row_sel < NUM_ROWS ? {1s, active[row_sel]} : 8'hFF.
  - While reading_port_b=1, kbd_data_out is held (frozen). A commit mid-read does not change it.
  - kbd_enable = reading_port_b & (kbd_data_out != 8'hFF). This is combinational, with zero latency from reading_port_b.
- key_pressed_any: registered. It reflects the active matrix one clk after any active change.
- Watchdog (TIMEOUT_CYCLES != 0):
  - The counter increments each clk and saturates.
  - When it reaches TIMEOUT_CYCLES-1: active rows <= all 1s and stale <= 1, both in that clk. The shadow rows are untouched.
  - A commit in the same clk as the timeout wins: commit data is loaded and stale stays 0.
- Simultaneous events: a Pi commit and a CPU row latch in the same clk both take effect. The port-B value tracks the new data in the next clk unless a read is in progress.
- Reset mid-read: kbd_data_out returns to 8'hFF and kbd_enable drops in the cycle after reset is sampled.

Test Plan:
1. Reset; Pi writes row 3 = 8'hFB, then commits 8'h01. CPU writes PORTA = 8'h03, then reads PORTB -> kbd_data_out = 8'hFB and kbd_enable = 1 for the whole read; key_pressed_any = 1.
2. Write row 3 = 8'hFB with no commit; CPU selects row 3 and reads -> kbd_data_out = 8'hFF, kbd_enable = 0. After a commit, the next read returns 8'hFB.
3. With row 3 = 8'hFB active, start a PORTB read and commit row 3 = 8'hFF mid-read -> output stays 8'hFB until the read ends; the next read gives kbd_enable = 0.
4. CPU selects row 12 with NUM_ROWS=10 -> kbd_data_out = 8'hFF, kbd_enable = 0. With COL_WIDTH=5 and row = 5'h1E committed -> a read returns 8'hFE.
5. TIMEOUT_CYCLES=100: commit a key, then idle 99 clks -> the active matrix releases, stale = 1, key_pressed_any = 0 one clk later. A commit issued exactly at the timeout cycle keeps the key and stale = 0.
6. Hold pi_write_strobe high for 5 clks on a row write -> exactly one shadow update. A control write of 8'h03 -> all rows are 8'hFF and stale = 0.

Source files
------------

// File: rtl/keyboard_matrix_cache.sv
// Keyboard-matrix cache for the PET clone: the Pi fills a shadow matrix and commits it atomically,
// while the CPU's PIA1 row-select and port-B reads are served from the committed (active) copy.
module keyboard_matrix_cache #(
  parameter int          NUM_ROWS       = 10,
  parameter int          COL_WIDTH      = 8,
  parameter logic [15:0] BASE_ADDR      = 16'hE800,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd6000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pi_addr,
  input  logic [7:0]  pi_data,
  input  logic        pi_write_strobe,
  input  logic [1:0]  bus_addr,
  input  logic [7:0]  bus_data_in,
  input  logic        bus_rw_b,
  input  logic        pia1_enabled_in,
  input  logic        io_select,
  input  logic        cpu_write_strobe,
  output logic [7:0]  kbd_data_out,
  output logic        kbd_enable,
  output logic        key_pressed_any,
  output logic        stale
);

  localparam logic [15:0]          CTRL_OFFSET = 16'd15;
  localparam logic [COL_WIDTH-1:0] ROW_IDLE    = '1;
  localparam logic [23:0]          WD_MAX      = '1;
  localparam logic [23:0]          WD_LAST     = TIMEOUT_CYCLES - 24'd1;

  logic [COL_WIDTH-1:0] shadow [NUM_ROWS];
  logic [COL_WIDTH-1:0] active [NUM_ROWS];

  logic        strobe_q;
  logic        pi_wr;
  logic [15:0] pi_offset;
  logic        ctrl_wr;
  logic        commit_bit;
  logic        release_req;
  logic        load_active;

  logic [23:0] wd_cnt;
  logic [23:0] wd_inc;
  logic        wd_fire;

  logic        writing_port_a;
  logic        writing_port_a_q;
  logic [3:0]  sel_hold;
  logic [3:0]  row_sel;
  logic        reading_port_b;

  logic [7:0]  sel_word;
  logic        any_low;
  logic        unused_bits;

  // Pi strobe acts once per rising edge, however long it is held.
  assign pi_wr       = pi_write_strobe & ~strobe_q;
  assign pi_offset   = pi_addr - BASE_ADDR;
  assign ctrl_wr     = pi_wr && (pi_offset == CTRL_OFFSET);
  assign commit_bit  = ctrl_wr & pi_data[0];
  assign release_req = ctrl_wr & pi_data[1];
  assign load_active = commit_bit & ~release_req;

  assign wd_inc  = (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + 24'd1;
  assign wd_fire = (TIMEOUT_CYCLES != 24'd0) && (wd_inc == WD_LAST);

  assign writing_port_a = cpu_write_strobe & pia1_enabled_in & (bus_addr == 2'd0);
  assign reading_port_b = io_select & bus_rw_b & pia1_enabled_in & (bus_addr == 2'd2);

  assign unused_bits = &{1'b0, bus_data_in[7:4], pi_data};

  // NOTE: every sequential process uses non-blocking assignments so all registers
  // update together on the edge and no process observes another's half-updated state.
  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= pi_write_strobe;
    end
  end

  // NOTE: the matrices are a handful of flops that must come up released, so they are
  // reset explicitly here; a large RAM-style array would normally be left unreset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        shadow[r] <= ROW_IDLE;
        active[r] <= ROW_IDLE;
      end
    end else begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (pi_wr && (pi_offset == 16'(r))) begin
          shadow[r] <= pi_data[COL_WIDTH-1:0];
        end
        if (release_req) begin
          shadow[r] <= ROW_IDLE;
          active[r] <= ROW_IDLE;
        end else if (load_active) begin
          active[r] <= shadow[r];
        end else if (wd_fire) begin
          active[r] <= ROW_IDLE;
        end
      end
    end
  end

  // A commit (even alongside release-all) restarts the watchdog and beats a same-cycle timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= 24'd0;
      stale  <= 1'b1;
    end else if (commit_bit) begin
      wd_cnt <= 24'd0;
      stale  <= 1'b0;
    end else begin
      wd_cnt <= wd_inc;
      if (wd_fire) begin
        stale <= 1'b1;
      end
    end
  end

  // Row select is taken from the last data seen while the PORTA write was active.
  always_ff @(posedge clk) begin
    if (reset) begin
      writing_port_a_q <= 1'b0;
      sel_hold         <= 4'd0;
      row_sel          <= 4'd0;
    end else begin
      writing_port_a_q <= writing_port_a;
      if (writing_port_a) begin
        sel_hold <= bus_data_in[3:0];
      end
      if (writing_port_a_q && !writing_port_a) begin
        row_sel <= sel_hold;
      end
    end
  end

  // NOTE: combinational outputs get their default first so no path leaves them
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    sel_word = 8'hFF;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (row_sel == 4'(r)) begin
        sel_word[COL_WIDTH-1:0] = active[r];
      end
    end
  end

  always_comb begin
    any_low = 1'b0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (active[r] != ROW_IDLE) begin
        any_low = 1'b1;
      end
    end
  end

  // The port-B value freezes for the duration of a read so the CPU sees one coherent byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      kbd_data_out    <= 8'hFF;
      key_pressed_any <= 1'b0;
    end else begin
      key_pressed_any <= any_low;
      if (!reading_port_b) begin
        kbd_data_out <= sel_word;
      end
    end
  end

  assign kbd_enable = reading_port_b & (kbd_data_out != 8'hFF);

endmodule

// File: tb/tb_keyboard_matrix_cache.sv
// Self-checking bench for keyboard_matrix_cache: directed scenarios followed by randomized
// Pi writes, commits, row selects and port-B reads, scored against a behavioural model.
module tb_keyboard_matrix_cache;

  localparam int          NR   = 10;
  localparam int          T    = 100;
  localparam logic [15:0] BASE = 16'hE800;
  localparam logic [15:0] CTRL = BASE + 16'd15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pi_addr = '0;
  logic [7:0]  pi_data = '0;
  logic        pi_write_strobe = 1'b0;
  logic [1:0]  bus_addr = '0;
  logic [7:0]  bus_data_in = '0;
  logic        bus_rw_b = 1'b0;
  logic        pia1_enabled_in = 1'b0;
  logic        io_select = 1'b0;
  logic        cpu_write_strobe = 1'b0;
  logic [7:0]  kbd_data_out;
  logic        kbd_enable;
  logic        key_pressed_any;
  logic        stale;

  keyboard_matrix_cache #(
    .NUM_ROWS(NR), .COL_WIDTH(5), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(24'd100)
  ) dut (
    .clk(clk), .reset(reset), .pi_addr(pi_addr), .pi_data(pi_data),
    .pi_write_strobe(pi_write_strobe), .bus_addr(bus_addr), .bus_data_in(bus_data_in),
    .bus_rw_b(bus_rw_b), .pia1_enabled_in(pia1_enabled_in), .io_select(io_select),
    .cpu_write_strobe(cpu_write_strobe), .kbd_data_out(kbd_data_out),
    .kbd_enable(kbd_enable), .key_pressed_any(key_pressed_any), .stale(stale)
  );

  always #5 clk = ~clk;

  // Model: what the Pi has written, what was last committed, and when.
  logic [4:0] m_shadow [NR];
  logic [4:0] m_committed [NR];
  bit         m_have_commit;
  int         m_commit_edge;
  logic [3:0] m_row_sel;
  int         edge_n = 0;
  int         checks = 0;
  int         errors = 0;
  bit         in_read = 0;
  logic [7:0] frozen = 8'hFF;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Keys stay live until TIMEOUT-1 edges after the last commit.
  function automatic bit live_at(input int e);
    return m_have_commit && (e < m_commit_edge + T - 1);
  endfunction

  function automatic logic [7:0] exp_out(input int e);
    int idx;
    idx = int'(m_row_sel);
    if (idx < NR && live_at(e)) return {3'b111, m_committed[idx]};
    return 8'hFF;
  endfunction

  function automatic logic [7:0] exp_kpa(input int e);
    if (!live_at(e)) return 8'd0;
    for (int i = 0; i < NR; i++) if (m_committed[i] != 5'h1F) return 8'd1;
    return 8'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
    if (in_read) begin
      check("read_hold_data", kbd_data_out, frozen);
      check("read_hold_en", {7'd0, kbd_enable}, {7'd0, frozen != 8'hFF});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_shadow[i]    = 5'h1F;
      m_committed[i] = 5'h1F;
    end
    m_have_commit = 0;
    m_commit_edge = 0;
    m_row_sel     = 4'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    model_reset();
    tick();
    check("rst_data", kbd_data_out, 8'hFF);
    check("rst_en", {7'd0, kbd_enable}, 8'd0);
    check("rst_kpa", {7'd0, key_pressed_any}, 8'd0);
    check("rst_stale", {7'd0, stale}, 8'd1);
  endtask

  task automatic pi_write(input logic [15:0] addr, input logic [7:0] data,
                          input int hold, input logic [7:0] data_late);
    int off;
    pi_addr = addr;
    pi_data = data;
    pi_write_strobe = 1'b1;
    tick();
    off = int'(addr) - int'(BASE);
    if (off >= 0 && off < NR) begin
      m_shadow[off] = data[4:0];
    end else if (off == 15) begin
      if (data[1]) begin
        for (int i = 0; i < NR; i++) begin
          m_shadow[i]    = 5'h1F;
          m_committed[i] = 5'h1F;
        end
      end else if (data[0]) begin
        for (int i = 0; i < NR; i++) m_committed[i] = m_shadow[i];
      end
      if (data[0]) begin
        m_have_commit = 1;
        m_commit_edge = edge_n;
      end
    end
    pi_data = data_late;
    for (int i = 1; i < hold; i++) tick();
    pi_write_strobe = 1'b0;
    tick();
  endtask

  task automatic select_row(input logic [7:0] val);
    pia1_enabled_in  = 1'b1;
    bus_rw_b         = 1'b0;
    bus_addr         = 2'd0;
    bus_data_in      = val;
    cpu_write_strobe = 1'b1;
    tick();
    cpu_write_strobe = 1'b0;
    pia1_enabled_in  = 1'b0;
    bus_data_in      = 8'h00;
    tick();
    m_row_sel = val[3:0];
  endtask

  task automatic start_read(input string tag);
    logic [7:0] exp;
    pia1_enabled_in = 1'b1;
    io_select       = 1'b1;
    bus_rw_b        = 1'b1;
    bus_addr        = 2'd2;
    #1;
    exp = exp_out(edge_n - 1);
    check({tag, "_data"}, kbd_data_out, exp);
    check({tag, "_en"}, {7'd0, kbd_enable}, {7'd0, exp != 8'hFF});
    check({tag, "_kpa"}, {7'd0, key_pressed_any}, exp_kpa(edge_n - 1));
    frozen  = exp;
    in_read = 1;
  endtask

  task automatic end_read();
    in_read         = 0;
    io_select       = 1'b0;
    bus_rw_b        = 1'b0;
    pia1_enabled_in = 1'b0;
    bus_addr        = 2'd0;
    #1;
    check("read_end_en", {7'd0, kbd_enable}, 8'd0);
    idle(2);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    int r;
    logic [7:0] v;

    // Commit a key in row 3, select it, read it.
    do_reset();
    pi_write(BASE + 16'd3, 8'hFB, 1, 8'hFB);
    pi_write(CTRL, 8'h01, 1, 8'h01);
    check("t1_stale", {7'd0, stale}, 8'd0);
    select_row(8'h03);
    idle(2);
    start_read("t1");
    check("t1_lit", kbd_data_out, 8'hFB);
    idle(3);
    end_read();

    // Shadow-only write is invisible until committed.
    do_reset();
    pi_write(BASE + 16'd3, 8'hFB, 1, 8'hFB);
    select_row(8'h03);
    idle(2);
    start_read("t2_nocommit");
    check("t2_nocommit_lit", kbd_data_out, 8'hFF);
    idle(2);
    end_read();
    pi_write(CTRL, 8'h01, 1, 8'h01);
    idle(2);
    start_read("t2_commit");
    check("t2_commit_lit", kbd_data_out, 8'hFB);
    idle(1);

    // Commit during the read: value frozen until the read ends.
    pi_write(BASE + 16'd3, 8'hFF, 1, 8'hFF);
    pi_write(CTRL, 8'h01, 1, 8'h01);
    end_read();
    start_read("t3_after");
    check("t3_after_en", {7'd0, kbd_enable}, 8'd0);
    idle(1);
    end_read();

    // Out-of-range row and narrow column width.
    select_row(8'h0C);
    idle(2);
    start_read("t4_row12");
    idle(1);
    end_read();
    pi_write(BASE + 16'd5, 8'h1E, 1, 8'h1E);
    pi_write(CTRL, 8'h01, 1, 8'h01);
    select_row(8'h05);
    idle(2);
    start_read("t4_narrow");
    check("t4_narrow_lit", kbd_data_out, 8'hFE);
    idle(1);
    end_read();

    // Watchdog expiry, then a commit landing exactly on the timeout edge.
    do_reset();
    pi_write(BASE + 16'd4, 8'hF7, 1, 8'hF7);
    pi_write(CTRL, 8'h01, 1, 8'h01);
    c = m_commit_edge;
    select_row(8'h04);
    while (edge_n < c + T - 2) tick();
    check("t5_before_stale", {7'd0, stale}, 8'd0);
    tick();
    check("t5_fire_stale", {7'd0, stale}, 8'd1);
    check("t5_fire_kpa", {7'd0, key_pressed_any}, 8'd1);
    tick();
    check("t5_after_kpa", {7'd0, key_pressed_any}, 8'd0);
    pi_write(CTRL, 8'h01, 1, 8'h01);
    c = m_commit_edge;
    while (edge_n < c + T - 2) tick();
    pi_write(CTRL, 8'h01, 1, 8'h01);
    check("t5_race_stale", {7'd0, stale}, 8'd0);
    idle(2);
    start_read("t5_race");
    check("t5_race_lit", kbd_data_out, 8'hF7);
    end_read();

    // Held strobe writes once; combined control byte releases everything.
    pi_write(BASE + 16'd2, 8'hFD, 5, 8'hEF);
    pi_write(CTRL, 8'h01, 1, 8'h01);
    select_row(8'h02);
    idle(2);
    start_read("t6_hold");
    check("t6_hold_lit", kbd_data_out, 8'hFD);
    end_read();
    pi_write(CTRL, 8'h03, 1, 8'h03);
    check("t6_ctrl3_stale", {7'd0, stale}, 8'd0);
    idle(2);
    start_read("t6_ctrl3");
    check("t6_ctrl3_kpa_lit", {7'd0, key_pressed_any}, 8'd0);
    end_read();

    // Randomized traffic against the model.
    for (int it = 0; it < 24; it++) begin
      r = int'($urandom_range(0, 14));
      v = 8'($urandom);
      pi_write(BASE + 16'(r), v, int'($urandom_range(1, 3)), 8'($urandom));
      if ($urandom_range(0, 3) != 0) pi_write(CTRL, 8'h01, 1, 8'h01);
      if ($urandom_range(0, 7) == 0) pi_write(CTRL, 8'($urandom_range(2, 3)), 1, 8'h00);
      select_row(8'($urandom_range(0, 15)));
      idle(2);
      start_read("rnd");
      idle(int'($urandom_range(1, 3)));
      end_read();
    end

    // Reset while a read is in progress.
    pi_write(BASE + 16'd1, 8'hFE, 1, 8'hFE);
    pi_write(CTRL, 8'h01, 1, 8'h01);
    select_row(8'h01);
    idle(2);
    start_read("t7_pre");
    in_read = 0;
    reset = 1'b1;
    tick();
    check("t7_rst_data", kbd_data_out, 8'hFF);
    check("t7_rst_en", {7'd0, kbd_enable}, 8'd0);
    reset = 1'b0;
    model_reset();
    end_read();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
